// File: rtl/list_sum_datapath.sv
// list_sum_datapath
//   Datapath for the linked-list summation engine. It walks a list stored in a
//   host-loadable node memory, under control of the list-sum FSM, and captures
//   the final sum.
//   Node layout: word p = value, word p+1 = next pointer, pointer 0 = end.
// Ports
//   clk, rst        clock (rising edge), async active-low reset
//   start, head_ptr run request and first-node address
//   LD_SUM/LD_NEXT  register load enables from the FSM
//   A_SEL           1: read value word at NEXT, 0: read pointer word at NEXT+1
//   SUM_SEL         1: accumulate mem_rdata, 0: clear SUM
//   NEXT_SEL        1: follow pointer from memory, 0: reload head_ptr
//   DONE            run complete, from the FSM
//   wr_en/addr/data host memory write port
//   next_zero       NEXT_d == 0, combinational, back to the FSM
//   result          sum captured on the rising edge of DONE
//   node_cnt        nodes accumulated in the current/last run (saturating)
//   sum_ovf         sticky carry out of the SUM adder during a run
//   result_valid    one-cycle pulse when result is captured
module list_sum_datapath #(
  parameter int N  = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] head_ptr,
  input  logic          LD_SUM,
  input  logic          LD_NEXT,
  input  logic          A_SEL,
  input  logic          SUM_SEL,
  input  logic          NEXT_SEL,
  input  logic          DONE,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  output logic          next_zero,
  output logic [N-1:0]  result,
  output logic [AW:0]   node_cnt,
  output logic          sum_ovf,
  output logic          result_valid
);

  localparam int DEPTH = 2**AW;

  logic [N-1:0]  mem [DEPTH];
  logic [N-1:0]  sum_q;
  logic [AW-1:0] next_q;
  logic          done_q;

  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_rdata;
  logic [N:0]    add;
  logic [N-1:0]  sum_d;
  logic [AW-1:0] next_d;
  logic          init;

  // Pointer word sits at NEXT+1; the AW-bit add wraps 0xFF -> 0x00 naturally.
  assign mem_addr  = A_SEL ? next_q : next_q + {{(AW-1){1'b0}}, 1'b1};
  // Async read sees pre-edge contents, so a same-cycle host write is not visible.
  assign mem_rdata = mem[mem_addr];

  assign add       = {1'b0, sum_q} + {1'b0, mem_rdata};
  assign sum_d     = SUM_SEL ? add[N-1:0] : '0;
  assign next_d    = NEXT_SEL ? mem_rdata[AW-1:0] : head_ptr;
  assign next_zero = (next_d == '0);

  assign init = start && !LD_SUM && !LD_NEXT && !DONE;

  // Node memory: not reset, written only by the host.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q        <= '0;
      next_q       <= '0;
      node_cnt     <= '0;
      sum_ovf      <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // Loads override init; init only fires when neither load is asserted.
      if (LD_SUM) begin
        sum_q <= sum_d;
        if (SUM_SEL) begin
          if (node_cnt != '1) node_cnt <= node_cnt + 1'b1;
          sum_ovf <= sum_ovf | add[N];
        end else begin
          node_cnt <= '0;
          sum_ovf  <= 1'b0;
        end
      end else if (init) begin
        sum_q    <= '0;
        node_cnt <= '0;
        sum_ovf  <= 1'b0;
      end

      if (LD_NEXT)   next_q <= next_d;
      else if (init) next_q <= head_ptr;

      // Capture only on the rising edge of DONE so a held DONE gives one pulse.
      done_q       <= DONE;
      result_valid <= DONE && !done_q;
      if (DONE && !done_q) result <= sum_q;
    end
  end

endmodule

// File: tb/tb_list_sum_datapath.sv
module tb_list_sum_datapath;
  localparam int N  = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, LD_SUM, LD_NEXT, A_SEL, SUM_SEL, NEXT_SEL, DONE, wr_en;
  logic [AW-1:0] head_ptr, wr_addr;
  logic [N-1:0]  wr_data;
  logic          next_zero;
  logic [N-1:0]  result;
  logic [AW:0]   node_cnt;
  logic          sum_ovf, result_valid;

  list_sum_datapath #(.N(N), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .head_ptr(head_ptr),
    .LD_SUM(LD_SUM), .LD_NEXT(LD_NEXT), .A_SEL(A_SEL), .SUM_SEL(SUM_SEL),
    .NEXT_SEL(NEXT_SEL), .DONE(DONE), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .next_zero(next_zero), .result(result),
    .node_cnt(node_cnt), .sum_ovf(sum_ovf), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int rv_cnt = 0;

  always @(negedge clk) if (rst === 1'b1 && result_valid === 1'b1) rv_cnt++;

  typedef struct {
    logic [AW-1:0] head;
    int            done_cyc;
    logic [N-1:0]  exp_result;
    int            exp_cnt;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    start = 0; LD_SUM = 0; LD_NEXT = 0; A_SEL = 0; SUM_SEL = 0;
    NEXT_SEL = 0; DONE = 0; wr_en = 0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [N-1:0] d);
    wr_addr = a; wr_data = d; wr_en = 1; step(); wr_en = 0;
  endtask

  // Behaves like the control FSM: init, then value/pointer step pairs until
  // next_zero, then DONE held for dcyc cycles.
  task automatic run(input logic [AW-1:0] h, input int dcyc, output int steps, output bit to);
    bit nz;
    head_ptr = h; start = 1; step(); start = 0;
    steps = 0; to = 1;
    for (int i = 0; i < 20; i++) begin
      A_SEL = 1; SUM_SEL = 1; LD_SUM = 1; step(); LD_SUM = 0;
      A_SEL = 0; NEXT_SEL = 1; LD_NEXT = 1; #1 nz = next_zero; step(); LD_NEXT = 0;
      steps++;
      if (nz) begin to = 0; break; end
    end
    DONE = 1; repeat (dcyc) step(); DONE = 0; step(); step();
  endtask

  initial begin
    int steps, rv0;
    bit to;
    idle(); head_ptr = '0; wr_addr = '0; wr_data = '0;
    rst = 0; #1;
    chk("reset_result", result, 0);
    chk("reset_cnt", node_cnt, 0);
    chk("reset_ovf", sum_ovf, 0);
    chk("reset_rv", result_valid, 0);
    #12 rst = 1; step();

    // three-node list, single node, overflow pair, wrap node
    wr(8'h10, 5);  wr(8'h11, 32'h20);
    wr(8'h20, 7);  wr(8'h21, 32'h30);
    wr(8'h30, 9);  wr(8'h31, 0);
    wr(8'h40, 32'hFFFF_FFFF); wr(8'h41, 0);
    wr(8'h50, 32'hFFFF_FFFF); wr(8'h51, 32'h60);
    wr(8'h60, 2);  wr(8'h61, 0);
    wr(8'hFF, 32'h1234); wr(8'h00, 0);

    vecs[0] = '{8'h10, 1, 32'd21,        3, 1'b0};
    vecs[1] = '{8'h40, 1, 32'hFFFF_FFFF, 1, 1'b0};
    vecs[2] = '{8'h50, 2, 32'd1,         2, 1'b1};
    vecs[3] = '{8'h10, 1, 32'd21,        3, 1'b0};  // clean rerun clears ovf
    vecs[4] = '{8'hFF, 3, 32'h1234,      1, 1'b0};

    for (int v = 0; v < 5; v++) begin
      rv0 = rv_cnt;
      run(vecs[v].head, vecs[v].done_cyc, steps, to);
      chk($sformatf("v%0d_timeout", v), to, 0);
      chk($sformatf("v%0d_steps", v), steps, vecs[v].exp_cnt);
      chk($sformatf("v%0d_result", v), result, vecs[v].exp_result);
      chk($sformatf("v%0d_cnt", v), node_cnt, vecs[v].exp_cnt);
      chk($sformatf("v%0d_ovf", v), sum_ovf, vecs[v].exp_ovf);
      chk($sformatf("v%0d_rv_pulses", v), rv_cnt - rv0, 1);
    end

    // Write/read collision: accumulate old 5 while host writes 0x99 there.
    rv0 = rv_cnt;
    head_ptr = 8'h10; start = 1; step(); start = 0;
    A_SEL = 1; SUM_SEL = 1; LD_SUM = 1;
    wr_addr = 8'h10; wr_data = 32'h99; wr_en = 1;
    step(); wr_en = 0;
    step(); LD_SUM = 0;            // second read sees 0x99: SUM = 5 + 0x99
    DONE = 1; repeat (4) step(); DONE = 0; step(); step();
    chk("coll_result", result, 32'h9E);
    chk("coll_cnt", node_cnt, 2);
    chk("coll_rv_pulses", rv_cnt - rv0, 1);

    // Async reset mid-run after overflow has been flagged.
    head_ptr = 8'h50; start = 1; step(); start = 0;
    A_SEL = 1; SUM_SEL = 1; LD_SUM = 1; step(); LD_SUM = 0;
    A_SEL = 0; NEXT_SEL = 1; LD_NEXT = 1; step(); LD_NEXT = 0;
    A_SEL = 1; LD_SUM = 1; step(); LD_SUM = 0;
    chk("pre_rst_ovf", sum_ovf, 1);
    chk("pre_rst_cnt", node_cnt, 2);
    rv0 = rv_cnt;
    #2 rst = 0; #1;
    chk("mid_rst_result", result, 0);
    chk("mid_rst_cnt", node_cnt, 0);
    chk("mid_rst_ovf", sum_ovf, 0);
    chk("mid_rst_rv", result_valid, 0);
    // NEXT cleared: pointer path with NEXT=0 reads word 1 ... use value path at 0
    A_SEL = 1; NEXT_SEL = 1; #1;
    chk("mid_rst_nz", next_zero, 1);   // mem[0] == 0 and NEXT reset to 0
    @(negedge clk); rst = 1; step();
    DONE = 1; step(); DONE = 0; step(); step();
    chk("post_rst_result", result, 0); // SUM was cleared by reset
    chk("post_rst_rv_pulses", rv_cnt - rv0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/list_sum_datapath.md
Name: list_sum_datapath

Overview:
- Datapath for the linked-list summation engine; sits directly downstream of the list-sum control FSM.
- Consumes the FSM's LD_SUM, LD_NEXT, A_SEL, SUM_SEL, NEXT_SEL and DONE.
- Returns next_zero to the FSM.
- Holds node memory (host-loadable), the SUM and NEXT registers, a node counter, a sticky overflow flag and a result capture register.

Parameters:
N, 32, data word width (node value and pointer words)
AW, 8, memory address width; depth = 2**AW words

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  run request (same signal fed to the FSM)
head_ptr  in  AW  address of first list node
LD_SUM  in  1  load enable for SUM
LD_NEXT  in  1  load enable for NEXT
A_SEL  in  1  1: memory addr = NEXT (value word); 0: addr = NEXT+1 (pointer word)
SUM_SEL  in  1  1: SUM_d = SUM + mem_rdata; 0: SUM_d = 0
NEXT_SEL  in  1  1: NEXT_d = mem_rdata[AW-1:0]; 0: NEXT_d = head_ptr
DONE  in  1  run complete, from FSM
wr_en  in  1  host memory write strobe
wr_addr  in  AW  host write address
wr_data  in  N  host write data
next_zero  out  1  NEXT_d == 0 (combinational, to FSM)
result  out  N  captured sum
node_cnt  out  AW+1  nodes accumulated in current/last run
sum_ovf  out  1  sticky: carry out of SUM adder during run
result_valid  out  1  one-cycle pulse when result captured

Behaviour:
- Node layout: word p = value, word p+1 = next pointer; pointer 0 = end of list. Address p+1 wraps mod 2**AW.
- Memory: 2**AW x N register array. Asynchronous read at mem_addr; synchronous write on clk when wr_en=1. Contents not reset.
- Host write to the address being read in the same cycle: read returns old data; the write lands at the edge. The host does not write while a run is active; the block does not block such writes.
- Reset (rst=0, async): SUM=0, NEXT=0, node_cnt=0, sum_ovf=0, result=0, result_valid=0. Reset mid-run abandons the run; no result_valid is produced.
- Run init: if start=1 and LD_SUM=0 and LD_NEXT=0 and DONE=0, at the edge:
  - SUM<=0, NEXT<=head_ptr, node_cnt<=0, sum_ovf<=0.
- LD_SUM=1 (takes precedence over init):
  - SUM<=SUM_d (N-bit, wraps).
  - If SUM_SEL=1: node_cnt<=node_cnt+1 (saturates at all-ones), and sum_ovf<=sum_ovf | carry_out.
  - If SUM_SEL=0: node_cnt<=0, sum_ovf<=0.
- LD_NEXT=1 (takes precedence over init): NEXT<=NEXT_d. LD_SUM and LD_NEXT may be asserted together; each acts independently.
- next_zero = (NEXT_d == 0), where NEXT_d is the mux output for the current cycle's NEXT_SEL and mem_rdata. Pointer bits above AW are ignored.
- Result capture: internal done_q = DONE delayed one cycle. On DONE=1 and done_q=0 (rising edge):
  - result<=SUM.
  - result_valid=1 for exactly one cycle.
  - DONE held high for multiple cycles gives one capture only.
  - result holds until the next capture or reset.
- No operand latency beyond one clock: SUM and NEXT update at the edge where the load is sampled. Outputs other than next_zero are registered.

Test Plan:
- Reset: drive rst=0 mid-operation with SUM=0x55 -> SUM, NEXT, result, node_cnt, sum_ovf, result_valid all 0 immediately (async).
- Three-node list: memory 0x10:5/0x20, 0x20:7/0x30, 0x30:9/0; head_ptr=0x10; run with FSM -> result=21, node_cnt=3, sum_ovf=0, one result_valid pulse; next_zero=1 only on the final pointer read.
- Single node with value 0xFFFFFFFF/0 -> result=0xFFFFFFFF, node_cnt=1, next_zero=1 on the first NEXT step.
- Overflow: two nodes 0xFFFFFFFF and 2 -> result=1, sum_ovf=1; a second run on a clean list -> sum_ovf cleared to 0 at init.
- Wrap: node at 0xFF, pointer word at 0x00 = 0 -> value read from 0xFF, pointer read from 0x00, run terminates; result equals the value at 0xFF.
- Write/read collision: host writes 0x99 to the address being read by A_SEL=1 in the same cycle -> SUM accumulates the old value; a subsequent read returns 0x99. DONE held 4 cycles -> exactly one result_valid.
